jump_ctrl: RTL and testbench

Control-transfer unit driving the program counter's `absjump_en` and `target` inputs from the decoded jump opcode and the current `prog_ctr`. Resolves unconditional jumps, conditional branches, calls and returns. Targets come from a writable jump-target lookup table; return addresses are kept on a small hardware return stack. Sits between decode and the program counter, closing the PC loop in the same cycle.

---
 rtl/jump_pkg.sv | 15 +
 rtl/ret_stack.sv | 64 ++++++
 rtl/jump_ctrl.sv | 129 ++++++++++++
 tb/tb_jump_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_pkg.sv
// Shared definitions for the control-transfer unit: the jump opcode
// encoding that decode presents to jump_ctrl.
package jump_pkg;

    localparam int JOP_W = 3;

    typedef enum logic [JOP_W-1:0] {
        JOP_NOP  = 3'd0,
        JOP_JMP  = 3'd1,
        JOP_BR   = 3'd2,
        JOP_CALL = 3'd3,
        JOP_RET  = 3'd4
    } jop_t;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack. A push when full or a pop when empty is
// silently ignored; the caller owns the overflow/underflow bookkeeping.
module ret_stack #(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [D-1:0]                 din,
    output logic [D-1:0]                 top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int DW = $clog2(DEPTH+1);

    logic [D-1:0]  stk_q [DEPTH];
    logic [D-1:0]  stk_d [DEPTH];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == {DW{1'b0}});
    assign depth = depth_q;

    // Top-of-stack select: entry depth-1, or zero when the stack is empty.
    always_comb begin
        top = {D{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            top = (depth_q == DW'(i + 1)) ? stk_q[i] : top;
        end
    end

    // Next-state for entries and occupancy; the new entry lands at index depth.
    always_comb begin
        stk_d   = stk_q;
        depth_d = depth_q;
        if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                stk_d[i] = (depth_q == DW'(i)) ? din : stk_q[i];
            end
            depth_d = depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DW'(1);
        end else begin
            depth_d = depth_q;
        end
    end

    // Stack state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stk_q   <= '{default: {D{1'b0}}};
            depth_q <= {DW{1'b0}};
        end else begin
            stk_q   <= stk_d;
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Control-transfer unit: decodes the jump opcode against the target LUT and
// return stack, driving the PC's absjump_en/target in the same cycle.
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int D     = 12,
    parameter int DEPTH = 4,
    parameter int LW    = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [D-1:0]                 prog_ctr,
    input  logic [2:0]                   op,
    input  logic [LW-1:0]                idx,
    input  logic                         cond,
    input  logic                         lut_we,
    input  logic [LW-1:0]                lut_waddr,
    input  logic [D-1:0]                 lut_wdata,
    output logic                         absjump_en,
    output logic [D-1:0]                 target,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int LN = 1 << LW;

    logic [D-1:0] lut_q [LN];
    logic [D-1:0] lut_d [LN];
    logic         overflow_q;
    logic         overflow_d;
    logic         underflow_q;
    logic         underflow_d;
    logic         push_s;
    logic         pop_s;
    logic [D-1:0] ret_addr_s;
    logic [D-1:0] top_s;
    logic         full_s;
    logic         empty_s;
    jop_t         op_s;

    assign op_s       = jop_t'(op);
    assign ret_addr_s = prog_ctr + {{(D-1){1'b0}}, 1'b1};
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

    ret_stack #(
        .D     (D),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (ret_addr_s),
        .top   (top_s),
        .depth (depth),
        .full  (full_s),
        .empty (empty_s)
    );

    // Opcode decode; reset forces a no-jump and blocks any stack action.
    always_comb begin
        absjump_en  = 1'b0;
        target      = {D{1'b0}};
        push_s      = 1'b0;
        pop_s       = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (reset) begin
            absjump_en = 1'b0;
            target     = {D{1'b0}};
        end else begin
            case (op_s)
                JOP_JMP: begin
                    absjump_en = 1'b1;
                    target     = lut_q[idx];
                end
                JOP_BR: begin
                    absjump_en = cond;
                    target     = lut_q[idx];
                end
                JOP_CALL: begin
                    absjump_en = 1'b1;
                    target     = lut_q[idx];
                    push_s     = 1'b1;
                    overflow_d = overflow_q | full_s;
                end
                JOP_RET: begin
                    if (!empty_s) begin
                        absjump_en = 1'b1;
                        target     = top_s;
                        pop_s      = 1'b1;
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                default: begin
                    absjump_en = 1'b0;
                    target     = {D{1'b0}};
                end
            endcase
        end
    end

    // LUT write path, independent of the opcode being decoded.
    always_comb begin
        lut_d = lut_q;
        if (lut_we && !reset) begin
            lut_d[lut_waddr] = lut_wdata;
        end else begin
            lut_d = lut_q;
        end
    end

    // LUT and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            lut_q       <= '{default: {D{1'b0}}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            lut_q       <= lut_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_jump_ctrl;
    import jump_pkg::*;

    localparam int D     = 12;
    localparam int DEPTH = 4;
    localparam int LW    = 5;
    localparam int DW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset;
    logic [D-1:0]  prog_ctr;
    logic [2:0]    op;
    logic [LW-1:0] idx;
    logic          cond;
    logic          lut_we;
    logic [LW-1:0] lut_waddr;
    logic [D-1:0]  lut_wdata;
    logic          absjump_en;
    logic [D-1:0]  target;
    logic [DW-1:0] depth;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [D-1:0] m_lut [1<<LW];
    logic [D-1:0] m_stk [$];
    logic         m_ovf;
    logic         m_unf;
    logic         exp_en;
    logic [D-1:0] exp_tgt;

    jump_ctrl #(.D(D), .DEPTH(DEPTH), .LW(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_ctr   (prog_ctr),
        .op         (op),
        .idx        (idx),
        .cond       (cond),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .absjump_en (absjump_en),
        .target     (target),
        .depth      (depth),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic model_expect();
        exp_en  = 1'b0;
        exp_tgt = '0;
        if (!reset) begin
            case (op)
                3'd1: begin exp_en = 1'b1; exp_tgt = m_lut[idx]; end
                3'd2: begin exp_en = cond; exp_tgt = m_lut[idx]; end
                3'd3: begin exp_en = 1'b1; exp_tgt = m_lut[idx]; end
                3'd4: if (m_stk.size() > 0) begin
                    exp_en  = 1'b1;
                    exp_tgt = m_stk[m_stk.size()-1];
                end
                default: ;
            endcase
        end
    endtask

    // Drive at posedge+1, settle to the negedge, compute expectations.
    task automatic drive(input logic r, input logic [2:0] o, input logic [LW-1:0] i,
                         input logic c, input logic [D-1:0] pc, input logic we,
                         input logic [LW-1:0] wa, input logic [D-1:0] wd);
        reset = r; op = o; idx = i; cond = c; prog_ctr = pc;
        lut_we = we; lut_waddr = wa; lut_wdata = wd;
        #4;
        model_expect();
    endtask

    // Commit the model with the current inputs, then advance one clock.
    task automatic tick();
        if (reset) begin
            foreach (m_lut[k]) m_lut[k] = '0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (op == 3'd3) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(prog_ctr + 12'd1);
                else m_ovf = 1'b1;
            end else if (op == 3'd4) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_unf = 1'b1;
            end
            if (lut_we) m_lut[lut_waddr] = lut_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 3'd1, 5'd3, 1'b1, 12'h010, 1'b1, 5'd3, 12'hABC);
        n_checks++; if (absjump_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", absjump_en); end
        n_checks++; if (target !== 12'h000) begin n_fail++; $display("FAIL reset_target: got %h expected 000", target); end
        tick();
        n_checks++; if (depth !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got depth=%0d ovf=%b unf=%b expected 0 0 0", depth, overflow, underflow);
        end
    endtask

    task automatic test_jmp_br();
        drive(1'b0, 3'd0, 5'd0, 1'b0, 12'h000, 1'b1, 5'd3, 12'h120);
        tick();
        drive(1'b0, 3'd1, 5'd3, 1'b0, 12'h000, 1'b0, 5'd0, 12'h000);
        n_checks++; if (absjump_en !== 1'b1 || target !== 12'h120) begin
            n_fail++; $display("FAIL jmp: got en=%b tgt=%h expected en=1 tgt=120", absjump_en, target);
        end
        tick();
        n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL jmp_depth: got %0d expected 0", depth); end
        drive(1'b0, 3'd2, 5'd3, 1'b0, 12'h000, 1'b0, 5'd0, 12'h000);
        n_checks++; if (absjump_en !== 1'b0 || target !== 12'h120) begin
            n_fail++; $display("FAIL br_not_taken: got en=%b tgt=%h expected en=0 tgt=120", absjump_en, target);
        end
        tick();
        drive(1'b0, 3'd2, 5'd3, 1'b1, 12'h000, 1'b0, 5'd0, 12'h000);
        n_checks++; if (absjump_en !== 1'b1 || target !== 12'h120) begin
            n_fail++; $display("FAIL br_taken: got en=%b tgt=%h expected en=1 tgt=120", absjump_en, target);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 3'd3, 5'd3, 1'b0, 12'h010, 1'b0, 5'd0, 12'h000);
        n_checks++; if (absjump_en !== 1'b1 || target !== 12'h120) begin
            n_fail++; $display("FAIL call: got en=%b tgt=%h expected en=1 tgt=120", absjump_en, target);
        end
        tick();
        n_checks++; if (depth !== 3'd1) begin n_fail++; $display("FAIL call_depth: got %0d expected 1", depth); end
        drive(1'b0, 3'd4, 5'd0, 1'b0, 12'h120, 1'b0, 5'd0, 12'h000);
        n_checks++; if (absjump_en !== 1'b1 || target !== 12'h011) begin
            n_fail++; $display("FAIL ret: got en=%b tgt=%h expected en=1 tgt=011", absjump_en, target);
        end
        tick();
        n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL ret_depth: got %0d expected 0", depth); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 3'd3, 5'd3, 1'b0, 12'h100 + 12'(k), 1'b0, 5'd0, 12'h000);
            tick();
            n_checks++; if (overflow !== (k == 4)) begin
                n_fail++; $display("FAIL ovf_call%0d: got %b expected %b", k, overflow, (k == 4));
            end
        end
        n_checks++; if (depth !== 3'd4) begin n_fail++; $display("FAIL ovf_depth: got %0d expected 4", depth); end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 3'd4, 5'd0, 1'b0, 12'h200, 1'b0, 5'd0, 12'h000);
            n_checks++; if (absjump_en !== 1'b1 || target !== 12'h104 - 12'(k)) begin
                n_fail++; $display("FAIL ret%0d: got en=%b tgt=%h expected en=1 tgt=%h", k, absjump_en, target, 12'h104 - 12'(k));
            end
            tick();
        end
        drive(1'b0, 3'd4, 5'd0, 1'b0, 12'h200, 1'b0, 5'd0, 12'h000);
        n_checks++; if (absjump_en !== 1'b0 || target !== 12'h000) begin
            n_fail++; $display("FAIL ret_empty: got en=%b tgt=%h expected en=0 tgt=000", absjump_en, target);
        end
        tick();
        n_checks++; if (underflow !== 1'b1 || depth !== 3'd0) begin
            n_fail++; $display("FAIL unf: got unf=%b depth=%0d expected 1 0", underflow, depth);
        end
    endtask

    task automatic test_lut_bypass();
        drive(1'b0, 3'd1, 5'd7, 1'b0, 12'h000, 1'b1, 5'd7, 12'h055);
        n_checks++; if (target !== 12'h000) begin n_fail++; $display("FAIL lut_old: got %h expected 000", target); end
        tick();
        drive(1'b0, 3'd1, 5'd7, 1'b0, 12'h000, 1'b0, 5'd0, 12'h000);
        n_checks++; if (target !== 12'h055) begin n_fail++; $display("FAIL lut_new: got %h expected 055", target); end
        tick();
    endtask

    task automatic test_wrap_reset();
        drive(1'b0, 3'd3, 5'd3, 1'b0, 12'hFFF, 1'b0, 5'd0, 12'h000);
        tick();
        drive(1'b0, 3'd4, 5'd0, 1'b0, 12'h120, 1'b0, 5'd0, 12'h000);
        n_checks++; if (absjump_en !== 1'b1 || target !== 12'h000) begin
            n_fail++; $display("FAIL wrap: got en=%b tgt=%h expected en=1 tgt=000", absjump_en, target);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 3'd3, 5'd3, 1'b0, 12'h300, 1'b0, 5'd0, 12'h000);
            tick();
        end
        n_checks++; if (depth !== 3'd2) begin n_fail++; $display("FAIL pre_reset_depth: got %0d expected 2", depth); end
        drive(1'b1, 3'd4, 5'd0, 1'b0, 12'h300, 1'b0, 5'd0, 12'h000);
        n_checks++; if (absjump_en !== 1'b0) begin n_fail++; $display("FAIL reset_ret_en: got %b expected 0", absjump_en); end
        tick();
        n_checks++; if (depth !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL midreset: got depth=%0d ovf=%b unf=%b expected 0 0 0", depth, overflow, underflow);
        end
        drive(1'b0, 3'd4, 5'd0, 1'b0, 12'h300, 1'b0, 5'd0, 12'h000);
        n_checks++; if (absjump_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_ret: got %b expected 0", absjump_en); end
        tick();
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL post_reset_unf: got %b expected 1", underflow); end
    endtask

    task automatic test_random();
        logic [2:0] op_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd6};
        for (int n = 0; n < 400; n++) begin
            logic [D-1:0] pc;
            pc = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom);
            drive(($urandom_range(0, 49) == 0), op_tab[$urandom_range(0, 9)], LW'($urandom_range(0, 7)),
                  1'($urandom), pc, ($urandom_range(0, 3) == 0), LW'($urandom_range(0, 7)), 12'($urandom));
            n_checks++; if (absjump_en !== exp_en || target !== exp_tgt) begin
                n_fail++; $display("FAIL rnd_out[%0d]: got en=%b tgt=%h expected en=%b tgt=%h", n, absjump_en, target, exp_en, exp_tgt);
            end
            tick();
            n_checks++; if (depth !== DW'(m_stk.size()) || overflow !== m_ovf || underflow !== m_unf) begin
                n_fail++; $display("FAIL rnd_state[%0d]: got depth=%0d ovf=%b unf=%b expected %0d %b %b",
                                   n, depth, overflow, underflow, m_stk.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        reset = 1'b1; op = 3'd0; idx = '0; cond = 1'b0; prog_ctr = '0;
        lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_jmp_br();
        test_back_to_back();
        test_overflow();
        test_lut_bypass();
        test_wrap_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
